// File: rtl/alu_seq.sv
// Registered, valid/ready ALU with a multi-cycle shift-add multiplier and sticky flags.
// Optional signed saturation of ADD/SUB is enabled by defining ALU_SAT_EN.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic [4:0]       flags,
  output logic [4:0]       sticky,
  input  logic             clr_sticky
);

  localparam int            CW     = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
  localparam logic [3:0]    OP_MUL = 4'd9;
`ifdef ALU_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]   a_p1;
  logic [WIDTH-1:0]   b_p1;
  logic [2*WIDTH-1:0] acc_p1;
  logic [CW-1:0]      cnt_p1;
  logic [WIDTH-1:0]   y_p2;
  logic [4:0]         flags_p2;
  logic               vld_p2;
  logic [4:0]         sticky_q;
  logic               accept;
  logic               accept_mul;
  logic [WIDTH+4:0]   single_res;
  logic [WIDTH-1:0]   mul_y;
  logic               mul_hi;

  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] y,
                                                input logic v, input logic neg);
    logic [WIDTH-1:0] clamp;
    clamp = neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    return (SAT_EN && v) ? clamp : y;
  endfunction

  function automatic logic [4:0] mk_flags(input logic [WIDTH-1:0] y,
                                          input logic v, input logic c);
    return {y[WIDTH-1], ~|y, v, ^y, c};
  endfunction

  // Returns {Y, flags} for every opcode that completes in one cycle.
  function automatic logic [WIDTH+4:0] single_op(input logic [3:0] sel,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic [WIDTH:0]        sum;
    logic [WIDTH:0]        shl;
    logic [WIDTH:0]        shr;
    logic signed [WIDTH:0] asr;
    logic [SHW-1:0]        amt;
    logic [WIDTH-1:0]      y;
    logic                  v;
    logic                  c;
    logic                  known;
    sum   = '0;
    shl   = '0;
    shr   = '0;
    asr   = '0;
    amt   = b[SHW-1:0];
    y     = '0;
    v     = 1'b0;
    c     = 1'b0;
    known = 1'b1;
    case (sel)
      4'd0: begin
        sum = {1'b0, a} + {1'b0, b};
        c   = sum[WIDTH];
        v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        y   = saturate(sum[WIDTH-1:0], v, a[WIDTH-1]);
      end
      4'd1: begin
        sum = {1'b0, a} - {1'b0, b};
        c   = sum[WIDTH];
        v   = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        y   = saturate(sum[WIDTH-1:0], v, a[WIDTH-1]);
      end
      4'd2: y = a & b;
      4'd3: y = a | b;
      4'd4: y = a ^ b;
      4'd5: y = ~a;
      4'd6: begin
        // One guard bit above/below the operand holds the last bit shifted out.
        shl = {1'b0, a} << amt;
        y   = shl[WIDTH-1:0];
        c   = shl[WIDTH];
      end
      4'd7: begin
        shr = {a, 1'b0} >> amt;
        y   = shr[WIDTH:1];
        c   = shr[0];
      end
      4'd8: begin
        asr = $signed({a, 1'b0}) >>> amt;
        y   = asr[WIDTH:1];
        c   = asr[0];
      end
      default: known = 1'b0;
    endcase
    return {y, known ? mk_flags(y, v, c) : 5'b0};
  endfunction

  assign accept     = in_valid & in_ready;
  assign accept_mul = accept & (Sel == OP_MUL);
  assign single_res = single_op(Sel, A, B);
  assign mul_y      = acc_p1[WIDTH-1:0];
  assign mul_hi     = |acc_p1[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_mul) state_nxt = MUL;
      MUL:     if (cnt_p1 == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE) & (~vld_p2 | out_ready);
  end

  // Stage 1: multiplier operand latch and shift-add accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_p1   <= '0;
      b_p1   <= '0;
      acc_p1 <= '0;
      cnt_p1 <= '0;
    end else if (accept_mul) begin
      a_p1   <= A;
      b_p1   <= B;
      acc_p1 <= '0;
      cnt_p1 <= '0;
    end else if (state == MUL) begin
      if (b_p1[cnt_p1])
        acc_p1 <= acc_p1 + ({{WIDTH{1'b0}}, a_p1} << cnt_p1);
      cnt_p1 <= cnt_p1 + 1'b1;
    end
  end

  // Stage 2: result register, held while the sink stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_p2     <= '0;
      flags_p2 <= '0;
      vld_p2   <= 1'b0;
    end else if (accept && !accept_mul) begin
      y_p2     <= single_res[WIDTH+4:5];
      flags_p2 <= single_res[4:0];
      vld_p2   <= 1'b1;
    end else if (state == DONE) begin
      y_p2     <= mul_y;
      flags_p2 <= mk_flags(mul_y, mul_hi, mul_hi);
      vld_p2   <= 1'b1;
    end else if (out_ready) begin
      vld_p2   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       sticky_q <= '0;
    else if (clr_sticky)           sticky_q <= '0;
    else if (vld_p2 && out_ready)  sticky_q <= sticky_q | flags_p2;
  end

  assign out_valid = vld_p2;
  assign Y         = y_p2;
  assign flags     = flags_p2;
  assign sticky    = sticky_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed, table-driven bench for alu_seq at WIDTH=4, plus hand-written
// sequences for reset-mid-MUL, MUL latency, backpressure streaming and sticky flags.
module tb_alu_seq;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [3:0]   Sel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Y;
  logic [4:0]   flags;
  logic [4:0]   sticky;
  logic         clr_sticky;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Sel(Sel), .out_valid(out_valid), .out_ready(out_ready),
    .Y(Y), .flags(flags), .sticky(sticky), .clr_sticky(clr_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sel;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] y;
    logic [4:0] f;
    string      name;
  } vec_t;

  vec_t       tbl[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic       mon_en = 1'b0;
  logic [3:0] rcv[$];

  always @(posedge clk)
    if (mon_en && out_valid && out_ready) rcv.push_back(Y);

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    Sel = s;
    A = a;
    B = b;
    while (!in_ready && n < 40) begin
      step();
      n++;
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: in_ready stuck at 0 for op %0d", s);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic get(output logic [3:0] y, output logic [4:0] f);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    if (!out_valid) begin
      n_vec++;
      n_err++;
      $display("FAIL get_timeout: out_valid never asserted");
    end
    y = Y;
    f = flags;
  endtask

  initial begin
    logic [3:0] gy;
    logic [4:0] gf;
    logic       bad;
    int         n;

    // {sel, a, b, expected Y, expected flags {S,Z,V,P,C}}
`ifdef ALU_SAT_EN
    tbl.push_back('{4'd0, 4'd7,  4'd1,  4'd7,  5'b00110, "add_pos_ovf"});
    tbl.push_back('{4'd1, 4'd8,  4'd1,  4'd8,  5'b10110, "sub_neg_ovf"});
`else
    tbl.push_back('{4'd0, 4'd7,  4'd1,  4'd8,  5'b10110, "add_pos_ovf"});
    tbl.push_back('{4'd1, 4'd8,  4'd1,  4'd7,  5'b00110, "sub_neg_ovf"});
`endif
    tbl.push_back('{4'd1, 4'd3,  4'd5,  4'he,  5'b10011, "sub_borrow"});
    tbl.push_back('{4'd0, 4'hf,  4'd1,  4'd0,  5'b01001, "add_carry_zero"});
    tbl.push_back('{4'd2, 4'hc,  4'ha,  4'h8,  5'b10010, "and"});
    tbl.push_back('{4'd3, 4'hc,  4'ha,  4'he,  5'b10010, "or"});
    tbl.push_back('{4'd4, 4'hc,  4'ha,  4'h6,  5'b00000, "xor"});
    tbl.push_back('{4'd5, 4'h5,  4'h0,  4'ha,  5'b10000, "not"});
    tbl.push_back('{4'd6, 4'hb,  4'd2,  4'hc,  5'b10000, "shl2"});
    tbl.push_back('{4'd6, 4'hb,  4'd0,  4'hb,  5'b10010, "shl0"});
    tbl.push_back('{4'd7, 4'hb,  4'd1,  4'h5,  5'b00001, "shr1"});
    tbl.push_back('{4'd7, 4'h8,  4'h7,  4'h1,  5'b00010, "shr_amt_lsbs"});
    tbl.push_back('{4'd8, 4'h9,  4'd2,  4'he,  5'b10010, "asr2"});
    tbl.push_back('{4'd8, 4'h8,  4'd3,  4'hf,  5'b10000, "asr3"});
    tbl.push_back('{4'd12, 4'h5, 4'h3,  4'h0,  5'b00000, "op12"});
    tbl.push_back('{4'd9, 4'd5,  4'd3,  4'hf,  5'b10000, "mul_5x3"});
    tbl.push_back('{4'd9, 4'hf,  4'hf,  4'h1,  5'b00111, "mul_15x15"});

    rst = 1'b1;
    in_valid = 1'b0;
    A = '0;
    B = '0;
    Sel = '0;
    out_ready = 1'b1;
    clr_sticky = 1'b0;
    repeat (2) step();
    check("rst_out_valid", {7'd0, out_valid}, 8'd0);
    check("rst_y", {4'd0, Y}, 8'd0);
    check("rst_flags", {3'd0, flags}, 8'd0);
    check("rst_sticky", {3'd0, sticky}, 8'd0);
    rst = 1'b0;
    step();
    check("rst_in_ready", {7'd0, in_ready}, 8'd1);

    foreach (tbl[i]) begin
      send(tbl[i].sel, tbl[i].a, tbl[i].b);
      if (tbl[i].sel != 4'd9)
        check({tbl[i].name, "_lat1"}, {7'd0, out_valid}, 8'd1);
      get(gy, gf);
      check({tbl[i].name, "_y"}, {4'd0, gy}, {4'd0, tbl[i].y});
      check({tbl[i].name, "_flags"}, {3'd0, gf}, {3'd0, tbl[i].f});
    end
    step();

    // Reset two cycles into a MUL: the op must vanish.
    send(4'd9, 4'd7, 4'd7);
    step();
    step();
    rst = 1'b1;
    #2;
    check("midmul_rst_sticky", {3'd0, sticky}, 8'd0);
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid) bad = 1'b1;
    end
    check("midmul_no_result", {7'd0, bad}, 8'd0);
    check("midmul_in_ready", {7'd0, in_ready}, 8'd1);

    // MUL latency: out_valid exactly WIDTH+1 cycles after accept.
    send(4'd9, 4'd5, 4'd3);
    n = 0;
    bad = 1'b0;
    while (!out_valid && n < 20) begin
      if (in_ready) bad = 1'b1;
      step();
      n++;
    end
    check("mul_latency", 8'(n), 8'd5);
    check("mul_in_ready_low", {7'd0, bad}, 8'd0);
    check("mul_lat_y", {4'd0, Y}, 8'h0f);
    step();

    // Backpressure: result held, inputs blocked, then stream one per cycle.
    rcv.delete();
    mon_en = 1'b1;
    out_ready = 1'b0;
    send(4'd2, 4'hc, 4'ha);
    in_valid = 1'b1;
    Sel = 4'd3;
    A = 4'hc;
    B = 4'ha;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (in_ready || !out_valid || Y !== 4'h8) bad = 1'b1;
      step();
    end
    check("stall_hold", {7'd0, bad}, 8'd0);
    out_ready = 1'b1;
    #1;
    check("stall_release_ready", {7'd0, in_ready}, 8'd1);
    step();
    Sel = 4'd4;
    step();
    in_valid = 1'b0;
    step();
    mon_en = 1'b0;
    check("stream_count", 8'(rcv.size()), 8'd3);
    if (rcv.size() == 3) begin
      check("stream_0", {4'd0, rcv[0]}, 8'h08);
      check("stream_1", {4'd0, rcv[1]}, 8'h0e);
      check("stream_2", {4'd0, rcv[2]}, 8'h06);
    end
    check("stream_drained", {7'd0, out_valid}, 8'd0);

    // Sticky accumulation and clear-priority.
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    check("sticky_cleared", {3'd0, sticky}, 8'd0);
    send(4'd0, 4'd7, 4'd1);
    get(gy, gf);
    send(4'd6, 4'd8, 4'd1);
    get(gy, gf);
    check("shl_8_1_flags", {3'd0, gf}, 8'b01001);
    step();
`ifdef ALU_SAT_EN
    check("sticky_or", {3'd0, sticky}, 8'b01111);
`else
    check("sticky_or", {3'd0, sticky}, 8'b11111);
`endif
    send(4'd1, 4'd3, 4'd5);
    get(gy, gf);
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    check("sticky_clr_prio", {3'd0, sticky}, 8'd0);
    send(4'd0, 4'hf, 4'd1);
    get(gy, gf);
    step();
    check("sticky_after_clr", {3'd0, sticky}, 8'b01001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
